// File: rtl/maria_dma_sched.sv
`default_nettype none
// ============================================================================
// maria_dma_sched : per-scanline beam counters and Maria DMA/halt scheduler
// Revision 1.0
// ============================================================================
module maria_dma_sched #(
  parameter int LINE_CYCLES   = 454,
  parameter int LINES         = 263,
  parameter int FIRST_LINE    = 16,
  parameter int LAST_LINE     = 258,
  parameter int DMA_START_CYC = 16,
  parameter int HALT_SETUP    = 2,
  parameter int DMA_KILL_CYC  = 424
) (
  input  logic       i_sysclk,
  input  logic       i_reset_n,
  input  logic       i_frame_sync,
  input  logic       i_dma_en,
  input  logic       i_zp_dma_done,
  input  logic       i_dp_dma_done,
  input  logic       i_dp_dma_done_dli,
  output logic       o_zp_dma_start,
  output logic       o_dp_dma_start,
  output logic       o_dp_dma_kill,
  output logic       o_halt_req,
  output logic       o_last_line,
  output logic       o_dli_nmi,
  output logic [8:0] o_hcnt,
  output logic [8:0] o_vline
);

  localparam logic [8:0] c_HMAX      = 9'(LINE_CYCLES - 1);
  localparam logic [8:0] c_VMAX      = 9'(LINES - 1);
  localparam logic [8:0] c_FIRST     = 9'(FIRST_LINE);
  localparam logic [8:0] c_LAST      = 9'(LAST_LINE);
  localparam logic [8:0] c_START     = 9'(DMA_START_CYC);
  localparam logic [8:0] c_KILL      = 9'(DMA_KILL_CYC);
  localparam logic [7:0] c_SETUP_END = 8'(HALT_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_ZP_WAIT = 3'd2,
    S_DP_RUN  = 3'd3,
    S_KILL    = 3'd4
  } state_t;

  state_t     r_state;
  logic [8:0] r_hcnt, r_vline;
  logic [7:0] r_setup;
  logic       r_zp_start, r_dp_start, r_kill, r_halt, r_last_line, r_dli_nmi, r_dli_pend;

  logic [8:0] w_hcnt_nxt, w_vline_nxt;
  logic       w_hwrap, w_dma_line;

  always_comb begin
    w_hwrap     = (r_hcnt == c_HMAX);
    w_hcnt_nxt  = w_hwrap ? 9'd0 : r_hcnt + 9'd1;
    w_vline_nxt = r_vline;
    if (w_hwrap)
      w_vline_nxt = (r_vline == c_VMAX) ? 9'd0 : r_vline + 9'd1;
    if (i_frame_sync) begin
      w_hcnt_nxt  = 9'd0;
      w_vline_nxt = 9'd0;
    end
  end

  assign w_dma_line = i_dma_en && (r_vline >= c_FIRST) && (r_vline <= c_LAST);

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_hcnt      <= 9'd0;
      r_vline     <= 9'd0;
      r_setup     <= 8'd0;
      r_zp_start  <= 1'b0;
      r_dp_start  <= 1'b0;
      r_kill      <= 1'b0;
      r_halt      <= 1'b0;
      r_last_line <= 1'b0;
      r_dli_nmi   <= 1'b0;
      r_dli_pend  <= 1'b0;
    end else begin
      r_hcnt      <= w_hcnt_nxt;
      r_vline     <= w_vline_nxt;
      // Derived from the next line value so last_line stays aligned with vline
      r_last_line <= (w_vline_nxt == c_LAST);
      r_zp_start  <= 1'b0;
      r_dp_start  <= 1'b0;
      r_dli_nmi   <= 1'b0;
      if (i_frame_sync) begin
        r_state    <= S_IDLE;
        r_halt     <= 1'b0;
        r_kill     <= 1'b0;
        r_setup    <= 8'd0;
        r_dli_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_dli_pend) begin
              r_dli_nmi  <= 1'b1;
              r_dli_pend <= 1'b0;
            end
            if (r_hcnt == c_START && w_dma_line) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
              r_setup <= 8'd0;
            end
          end
          S_HALT: begin
            if (r_setup == c_SETUP_END) begin
              if (r_vline == c_FIRST) begin
                r_zp_start <= 1'b1;
                r_state    <= S_ZP_WAIT;
              end else begin
                r_dp_start <= 1'b1;
                r_state    <= S_DP_RUN;
              end
            end else begin
              r_setup <= r_setup + 8'd1;
            end
          end
          S_ZP_WAIT: begin
            if (i_zp_dma_done) begin
              r_dp_start <= 1'b1;
              r_state    <= S_DP_RUN;
              if (i_dp_dma_done_dli) r_dli_pend <= 1'b1;
            end
          end
          S_DP_RUN: begin
            // A done on the deadline cycle takes priority over the kill
            if (i_dp_dma_done) begin
              r_halt  <= 1'b0;
              r_state <= S_IDLE;
              if (i_dp_dma_done_dli) r_dli_pend <= 1'b1;
            end else if (r_hcnt == c_KILL) begin
              r_kill  <= 1'b1;
              r_state <= S_KILL;
            end
          end
          S_KILL: begin
            if (i_dp_dma_done) begin
              r_kill  <= 1'b0;
              r_halt  <= 1'b0;
              r_state <= S_IDLE;
              if (i_dp_dma_done_dli) r_dli_pend <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_zp_dma_start = r_zp_start;
  assign o_dp_dma_start = r_dp_start;
  assign o_dp_dma_kill  = r_kill;
  assign o_halt_req     = r_halt;
  assign o_last_line    = r_last_line;
  assign o_dli_nmi      = r_dli_nmi;
  assign o_hcnt         = r_hcnt;
  assign o_vline        = r_vline;

endmodule
`default_nettype wire

// File: tb/tb_maria_dma_sched.sv
`default_nettype none
// ============================================================================
// tb_maria_dma_sched : directed, table-driven bench for maria_dma_sched
// Revision 1.0
// ============================================================================
module tb_maria_dma_sched;

  localparam int LINE_CYCLES = 454;
  localparam int LINES       = 13;
  localparam int FIRST_LINE  = 4;
  localparam int LAST_LINE   = 10;
  localparam int GOTO_LIMIT  = LINES * LINE_CYCLES + 10;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_frame_sync = 1'b0, i_dma_en = 1'b0;
  logic       i_zp_dma_done = 1'b0, i_dp_dma_done = 1'b0, i_dp_dma_done_dli = 1'b0;
  logic       o_zp_dma_start, o_dp_dma_start, o_dp_dma_kill, o_halt_req, o_last_line, o_dli_nmi;
  logic [8:0] o_hcnt, o_vline;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  maria_dma_sched #(
    .LINE_CYCLES(LINE_CYCLES), .LINES(LINES), .FIRST_LINE(FIRST_LINE),
    .LAST_LINE(LAST_LINE), .DMA_START_CYC(16), .HALT_SETUP(2), .DMA_KILL_CYC(424)
  ) dut (
    .i_sysclk(clk), .i_reset_n(i_reset_n), .i_frame_sync(i_frame_sync),
    .i_dma_en(i_dma_en), .i_zp_dma_done(i_zp_dma_done), .i_dp_dma_done(i_dp_dma_done),
    .i_dp_dma_done_dli(i_dp_dma_done_dli), .o_zp_dma_start(o_zp_dma_start),
    .o_dp_dma_start(o_dp_dma_start), .o_dp_dma_kill(o_dp_dma_kill),
    .o_halt_req(o_halt_req), .o_last_line(o_last_line), .o_dli_nmi(o_dli_nmi),
    .o_hcnt(o_hcnt), .o_vline(o_vline)
  );

  // Per-line scenario: inputs, then hcnt at which each event is expected (-1 = never)
  typedef struct {
    int vl; bit en; int zp_h; int dp_h; bit dli;
    int e_halt; int e_zp; int e_dp; int e_kill; int e_fall; int e_nmi; int e_last;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bail(input string name);
    chk(name, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic goto_line(input int vl);
    int guard = 0;
    while (!(int'(o_vline) == vl && o_hcnt == 9'd0) && guard < GOTO_LIMIT) begin
      step();
      guard++;
    end
    if (guard >= GOTO_LIMIT) bail("goto_timeout");
  endtask

  task automatic run_line(input vec_t v, input int idx);
    int h;
    int halt_r = -1, zp_r = -1, dp_r = -1, kill_r = -1, fall_r = -1, nmi_r = -1;
    int last_v = -1, dp_n = 0, nmi_n = 0;
    logic prev_halt;
    string t;
    prev_halt = o_halt_req;
    i_dma_en  = v.en;
    for (int c = 0; c < LINE_CYCLES; c++) begin
      h = int'(o_hcnt);
      if (o_halt_req && !prev_halt && halt_r < 0) halt_r = h;
      if (!o_halt_req && prev_halt && fall_r < 0) fall_r = h;
      prev_halt = o_halt_req;
      if (o_zp_dma_start && zp_r < 0) zp_r = h;
      if (o_dp_dma_start) begin dp_n++; if (dp_r < 0) dp_r = h; end
      if (o_dp_dma_kill && kill_r < 0) kill_r = h;
      if (o_dli_nmi) begin nmi_n++; if (nmi_r < 0) nmi_r = h; end
      if (h == 5) last_v = int'(o_last_line);
      i_zp_dma_done     = (h == v.zp_h);
      i_dp_dma_done     = (h == v.dp_h);
      i_dp_dma_done_dli = v.dli && (h == v.zp_h || h == v.dp_h);
      step();
    end
    i_zp_dma_done = 1'b0; i_dp_dma_done = 1'b0; i_dp_dma_done_dli = 1'b0; i_dma_en = 1'b0;
    t = $sformatf("v%0d_", idx);
    chk({t, "halt_rise"}, halt_r, v.e_halt);
    chk({t, "zp_start"},  zp_r,   v.e_zp);
    chk({t, "dp_start"},  dp_r,   v.e_dp);
    chk({t, "kill_rise"}, kill_r, v.e_kill);
    chk({t, "halt_fall"}, fall_r, v.e_fall);
    chk({t, "dli_nmi"},   nmi_r,  v.e_nmi);
    chk({t, "last_line"}, last_v, v.e_last);
    chk({t, "dp_count"},  dp_n,   (v.e_dp >= 0) ? 1 : 0);
    chk({t, "nmi_count"}, nmi_n,  (v.e_nmi >= 0) ? 1 : 0);
  endtask

  initial begin
    int seen;
    //           vl en  zp   dp  dli halt  zp  dp  kill fall nmi last
    vecs[0] = '{1,  1, -1,  -1,  0,  -1, -1, -1,  -1,  -1,  -1, 0};
    vecs[1] = '{4,  1, 30, 200,  0,  17, 19, 31,  -1, 201,  -1, 0};
    vecs[2] = '{5,  1, -1, 200,  1,  17, -1, 19,  -1, 201, 202, 0};
    vecs[3] = '{6,  0, -1,  -1,  0,  -1, -1, -1,  -1,  -1,  -1, 0};
    vecs[4] = '{7,  1, -1, 430,  0,  17, -1, 19, 425, 431,  -1, 0};
    vecs[5] = '{8,  1, -1, 424,  0,  17, -1, 19,  -1, 425,  -1, 0};
    vecs[6] = '{9,  1, -1, 430,  1,  17, -1, 19, 425, 431, 432, 0};
    vecs[7] = '{10, 1, -1, 100,  0,  17, -1, 19,  -1, 101,  -1, 1};
    vecs[8] = '{11, 1, -1,  -1,  0,  -1, -1, -1,  -1,  -1,  -1, 0};

    #3;
    chk("rst_halt", int'(o_halt_req), 0);
    chk("rst_hcnt", int'(o_hcnt), 0);
    chk("rst_outs", int'({o_zp_dma_start, o_dp_dma_start, o_dp_dma_kill, o_last_line, o_dli_nmi}), 0);

    @(posedge clk); #1;
    i_reset_n = 1'b1;
    seen = 0;
    repeat (LINE_CYCLES) begin
      step();
      if (o_halt_req || o_zp_dma_start || o_dp_dma_start) seen++;
    end
    chk("wrap_hcnt", int'(o_hcnt), 0);
    chk("wrap_vline", int'(o_vline), 1);
    chk("wrap_no_dma", seen, 0);

    repeat (37) step();
    i_frame_sync = 1'b1; step(); i_frame_sync = 1'b0;
    chk("fsync_hcnt", int'(o_hcnt), 0);
    chk("fsync_vline", int'(o_vline), 0);

    foreach (vecs[i]) begin
      goto_line(vecs[i].vl);
      run_line(vecs[i], i);
    end

    // Asynchronous reset while the engine is being killed
    goto_line(7);
    i_dma_en = 1'b1;
    repeat (426) step();
    chk("kill_held", int'(o_dp_dma_kill), 1);
    chk("kill_halt", int'(o_halt_req), 1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_kill", int'(o_dp_dma_kill), 0);
    chk("arst_halt", int'(o_halt_req), 0);
    chk("arst_cnt", int'({o_hcnt, o_vline}), 0);
    i_dma_en = 1'b0;
    @(posedge clk); #1;
    i_reset_n = 1'b1;

    // frame_sync in the middle of DP DMA
    goto_line(5);
    i_dma_en = 1'b1;
    repeat (100) step();
    chk("dprun_halt", int'(o_halt_req), 1);
    i_frame_sync = 1'b1; step(); i_frame_sync = 1'b0;
    chk("fs_dp_hcnt", int'(o_hcnt), 0);
    chk("fs_dp_vline", int'(o_vline), 0);
    chk("fs_dp_halt", int'(o_halt_req), 0);
    seen = 0;
    repeat (500) begin
      if (o_halt_req || o_zp_dma_start || o_dp_dma_start || o_dp_dma_kill || o_dli_nmi) seen++;
      step();
    end
    chk("fs_dp_quiet", seen, 0);
    i_dma_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
